// File: rtl/iter_rotl_shifter.sv
// Multi-cycle left rotator / logical left shifter.
// Each SHIFT cycle moves the operand left by at most STEP bit positions, so the
// datapath needs only a narrow shift stage instead of a full barrel shifter.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         request, sampled only while ready=1
//   op            0 = rotate left, 1 = logical shift left (zero fill)
//   A, SH         operand and shift amount, captured on an accepted start
//   ready         state is IDLE or DONE (decoded from the state)
//   busy          state is SHIFT (decoded from the state)
//   done          registered one-cycle pulse on entry to DONE
//   F             registered result, held until the next DONE entry
module iter_rotl_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SH_W  = 5,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [SH_W-1:0]  SH,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [SH_W-1:0]  cnt, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] f_d;
  logic             done_d;
  logic [SH_W-1:0]  k;
  logic [SH_W:0]    rsh;
  logic [WIDTH-1:0] shifted;

  // Status flags decode the state directly.
  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == SHIFT);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_q  <= 1'b0;
      F     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      F     <= f_d;
      done  <= done_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    op_d    = op_q;
    f_d     = F;
    done_d  = 1'b0;
    // Step size for this cycle; the STEP constant is only narrowed when it is
    // known to be smaller than cnt, so it always fits in SH_W bits.
    if (32'(cnt) <= STEP) k = cnt;
    else                  k = SH_W'(STEP);
    // k is non-zero whenever the rotate result is used, so rsh < WIDTH.
    rsh     = (SH_W+1)'(WIDTH) - (SH_W+1)'(k);
    shifted = op_q ? (acc << k) : ((acc << k) | (acc >> rsh));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          acc_d = A;
          cnt_d = SH;
          op_d  = op;
          if (SH == '0) begin
            f_d     = A;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt - k;
        if (32'(cnt) <= STEP) begin
          f_d     = shifted;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
